// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus bit-serial shifts and a
// shift-add multiplier sharing one working register pair.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             I_CLK,
    input  logic             I_NRESET,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [3:0]       I_OPCODE,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    output logic             O_VALID,
    output logic [WIDTH-1:0] O_C,
    output logic [4:0]       O_STATUS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDU  = 4'd1;
    localparam logic [3:0] OP_ADDC  = 4'd2;
    localparam logic [3:0] OP_ADDCU = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_LSH   = 4'd10;
    localparam logic [3:0] OP_RSH   = 4'd11;
    localparam logic [3:0] OP_ALSH  = 4'd12;
    localparam logic [3:0] OP_ARSH  = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_ZERO  = 4'd15;

    localparam logic [CNT_W-1:0] K_MAX   = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] B_LIMIT = WIDTH'(WIDTH);

    // Returns {N, Z, F, L, C, result} for every single-cycle opcode.
    function automatic logic [WIDTH+4:0] single_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   s_ext;
        logic [WIDTH:0]   u_sum;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             l;
        logic             f;
        logic             n;
        s_ext = '0;
        u_sum = '0;
        r     = '0;
        c     = 1'b0;
        l     = 1'b0;
        f     = 1'b0;
        n     = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                s_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b}
                      + {{WIDTH{1'b0}}, (op == OP_ADDC)};
                r = s_ext[WIDTH-1:0];
                f = s_ext[WIDTH] ^ s_ext[WIDTH-1];
                n = s_ext[WIDTH-1];
            end
            OP_ADDU, OP_ADDCU: begin
                u_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDCU)};
                r = u_sum[WIDTH-1:0];
                c = u_sum[WIDTH];
            end
            OP_SUB: begin
                // The extended difference carries the true sign, so it doubles as B<A.
                s_ext = {b[WIDTH-1], b} - {a[WIDTH-1], a};
                r = s_ext[WIDTH-1:0];
                f = s_ext[WIDTH] ^ s_ext[WIDTH-1];
                n = s_ext[WIDTH];
            end
            OP_SUBU: begin
                r = b - a;
                c = (b < a);
                l = (b < a);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_ZERO: r = '0;
            default: r = '0;
        endcase
        return {n, (r == '0), f, l, c, r};
    endfunction

    // One bit of shift for the serial shifter.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_LSH, OP_ALSH: r = {v[WIDTH-2:0], 1'b0};
            OP_RSH:          r = {1'b0, v[WIDTH-1:1]};
            OP_ARSH:         r = {v[WIDTH-1], v[WIDTH-1:1]};
            default:         r = v;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [4:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;

    logic [WIDTH+4:0] single_s;
    logic [CNT_W-1:0] k_s;
    logic             is_iter_s;
    logic [WIDTH:0]   step_sum_s;
    logic [WIDTH-1:0] step_work_s;
    logic [WIDTH-1:0] step_hi_s;

    assign single_s  = single_op(I_OPCODE, I_A, I_B);
    assign k_s       = (I_B >= B_LIMIT) ? K_MAX : I_B[CNT_W-1:0];
    assign is_iter_s = (I_OPCODE >= OP_LSH) && (I_OPCODE <= OP_MUL);

    // One iteration step: multiplier low bit adds into the high half, then {hi,work} shifts right.
    always_comb begin
        step_sum_s = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        if (op_q == OP_MUL) begin
            step_work_s = {step_sum_s[0], work_q[WIDTH-1:1]};
            step_hi_s   = step_sum_s[WIDTH:1];
        end else begin
            step_work_s = shift_one(op_q, work_q);
            step_hi_s   = hi_q;
        end
    end

    // Next-state and next-output logic for the control FSM.
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        c_d      = c_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        work_d   = work_q;
        hi_d     = hi_q;
        mcand_d  = mcand_q;
        case (state_q)
            IDLE: begin
                if (I_VALID && is_iter_s) begin
                    op_d    = I_OPCODE;
                    hi_d    = '0;
                    mcand_d = I_A;
                    if (I_OPCODE == OP_MUL) begin
                        work_d  = I_B;
                        cnt_d   = K_MAX;
                        state_d = ITER;
                    end else if (k_s == '0) begin
                        work_d   = I_A;
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        c_d      = I_A;
                        status_d = {1'b0, (I_A == '0), 3'b000};
                    end else begin
                        work_d  = I_A;
                        cnt_d   = k_s;
                        state_d = ITER;
                    end
                end else if (I_VALID) begin
                    valid_d  = 1'b1;
                    c_d      = single_s[WIDTH-1:0];
                    status_d = single_s[WIDTH+4:WIDTH];
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                work_d = step_work_s;
                hi_d   = step_hi_s;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    c_d      = step_work_s;
                    status_d = {1'b0, (step_work_s == '0), 2'b00,
                                (op_q == OP_MUL) && (step_hi_s != '0)};
                end else begin
                    state_d = ITER;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            c_q      <= '0;
            status_q <= 5'b00000;
            cnt_q    <= '0;
            op_q     <= 4'd0;
            work_q   <= '0;
            hi_q     <= '0;
            mcand_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            c_q      <= c_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            mcand_q  <= mcand_d;
        end
    end

    assign O_READY  = ready_q;
    assign O_VALID  = valid_q;
    assign O_C      = c_q;
    assign O_STATUS = status_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=16: expected results come from an integer
// reference model and are queued at issue time, popped when O_VALID appears.
module tb_alu_mc;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] c;
        logic [4:0]   st;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] out_c;
    logic [4:0]   out_st;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .I_CLK    (clk),
        .I_NRESET (rst_n),
        .I_VALID  (in_valid),
        .O_READY  (out_ready),
        .I_OPCODE (opcode),
        .I_A      (a),
        .I_B      (b),
        .O_VALID  (out_valid),
        .O_C      (out_c),
        .O_STATUS (out_st)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        longint       sx, sy, s;
        logic [31:0]  u;
        logic [W-1:0] r;
        logic         c, l, f, n;
        int           amt;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s = 0; u = 32'd0; r = '0;
        c = 1'b0; l = 1'b0; f = 1'b0; n = 1'b0;
        e.lat = 1;
        amt = (y >= 16'd16) ? 16 : int'(y);
        case (op)
            4'd0, 4'd2: begin
                s = sx + sy + ((op == 4'd2) ? 1 : 0);
                r = s[15:0];
                f = (s > 32767) || (s < -32768);
                n = r[15];
            end
            4'd1, 4'd3: begin
                u = 32'(x) + 32'(y) + ((op == 4'd3) ? 32'd1 : 32'd0);
                r = u[15:0];
                c = (u > 32'd65535);
            end
            4'd4: begin
                s = sy - sx;
                r = s[15:0];
                f = (s > 32767) || (s < -32768);
                n = (sy < sx);
            end
            4'd5: begin
                r = y - x;
                c = (y < x);
                l = (y < x);
            end
            4'd6: r = x & y;
            4'd7: r = x | y;
            4'd8: r = x ^ y;
            4'd9: r = ~x;
            4'd10, 4'd12: begin r = (amt >= 16) ? 16'h0000 : (x << amt); e.lat = amt + 1; end
            4'd11: begin r = (amt >= 16) ? 16'h0000 : (x >> amt); e.lat = amt + 1; end
            4'd13: begin
                r = (amt >= 16) ? {16{x[15]}} : W'($signed(x) >>> amt);
                e.lat = amt + 1;
            end
            4'd14: begin
                u = 32'(x) * 32'(y);
                r = u[15:0];
                c = (u[31:16] != 16'h0000);
                e.lat = 17;
            end
            default: r = 16'h0000;
        endcase
        e.c  = r;
        e.st = {n, (r == 16'h0000), f, l, c};
        return e;
    endfunction

    // Drive one request at the current negedge, queue its expectation, then scramble inputs.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        opcode   = op;
        a        = x;
        b        = y;
        exp_q.push_back(model(op, x, y));
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Wait (bounded) for O_VALID; reports latency and how many cycles O_READY was low.
    task automatic wait_valid(output int lat, output int busy);
        lat  = 1;
        busy = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (out_ready === 1'b0) busy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; opcode = 4'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", out_ready); end
        checks++; if (out_c !== 16'h0000) begin errors++; $display("FAIL reset_c: got %h want 0000", out_c); end
        checks++; if (out_st !== 5'b00000) begin errors++; $display("FAIL reset_status: got %b want 00000", out_st); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [3:0]   ops[12] = '{4'd0, 4'd5, 4'd2, 4'd3, 4'd1, 4'd4, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
        logic [W-1:0] xs[12]  = '{16'h7FFF, 16'h0005, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8000,
                                  16'h0003, 16'hF0F0, 16'h0F00, 16'hAAAA, 16'hFFFF, 16'h1234};
        logic [W-1:0] ys[12]  = '{16'h0001, 16'h0003, 16'h0000, 16'h0000, 16'h0001, 16'h0001,
                                  16'h0003, 16'h0FF0, 16'h00F0, 16'hAAAA, 16'h0000, 16'h5678};
        exp_t e;
        int   lat, busy;
        for (int i = 0; i < 12; i++) begin
            checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL single_ready[%0d]: got %b want 1", i, out_ready); end
            issue(ops[i], xs[i], ys[i]);
            wait_valid(lat, busy);
            e = exp_q.pop_front();
            checks++; if (lat != e.lat) begin errors++; $display("FAIL single_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (out_c !== e.c) begin errors++; $display("FAIL single_c[%0d] op%0d: got %h want %h", i, ops[i], out_c, e.c); end
            checks++; if (out_st !== e.st) begin errors++; $display("FAIL single_status[%0d] op%0d: got %b want %b", i, ops[i], out_st, e.st); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        exp_t         e;
        logic [3:0]   op;
        int           r;
        logic [W-1:0] last_c;
        last_c = '0;
        for (int i = 0; i < 10; i++) begin
            r  = int'($urandom_range(0, 10));
            op = (r == 10) ? 4'd15 : 4'(r);
            in_valid = 1'b1;
            opcode   = op;
            a        = W'($urandom);
            b        = W'($urandom);
            exp_q.push_back(model(op, a, b));
            @(negedge clk);
            e = exp_q.pop_front();
            last_c = e.c;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_c !== e.c) begin errors++; $display("FAIL b2b_c[%0d] op%0d: got %h want %h", i, op, out_c, e.c); end
            checks++; if (out_st !== e.st) begin errors++; $display("FAIL b2b_status[%0d] op%0d: got %b want %b", i, op, out_st, e.st); end
        end
        in_valid = 1'b0;
        a = W'($urandom);
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b want 0", out_valid); end
        checks++; if (out_c !== last_c) begin errors++; $display("FAIL b2b_hold: got %h want %h", out_c, last_c); end
    endtask

    task automatic test_shift;
        logic [3:0]   ops[9] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd11, 4'd10, 4'd13, 4'd13, 4'd12};
        logic [W-1:0] xs[9]  = '{16'h0001, 16'h8000, 16'h0003, 16'h8000, 16'hFFFF, 16'h0001,
                                 16'h7000, 16'h8000, 16'h1234};
        logic [W-1:0] ys[9]  = '{16'd4, 16'd3, 16'd0, 16'd20, 16'd16, 16'd15, 16'd2, 16'd15, 16'hFFFF};
        exp_t e;
        int   lat, busy;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], xs[i], ys[i]);
            wait_valid(lat, busy);
            e = exp_q.pop_front();
            checks++; if (lat != e.lat) begin errors++; $display("FAIL shift_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (busy != e.lat - 1) begin errors++; $display("FAIL shift_busy[%0d]: got %0d want %0d", i, busy, e.lat - 1); end
            checks++; if (out_c !== e.c) begin errors++; $display("FAIL shift_c[%0d] op%0d: got %h want %h", i, ops[i], out_c, e.c); end
            checks++; if (out_st !== e.st) begin errors++; $display("FAIL shift_status[%0d]: got %b want %b", i, out_st, e.st); end
            @(negedge clk);
        end
    endtask

    task automatic test_mul;
        logic [W-1:0] xs[6] = '{16'h0100, 16'h0003, 16'hFFFF, 16'h0000, 16'h00FF, 16'h1234};
        logic [W-1:0] ys[6] = '{16'h0100, 16'h0005, 16'hFFFF, 16'h1234, 16'h0101, 16'h0010};
        exp_t e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            issue(4'd14, xs[i], ys[i]);
            lat = 1;
            while (out_valid !== 1'b1 && lat < 64) begin
                in_valid = (lat == 5);
                opcode   = 4'd0;
                @(negedge clk);
                lat++;
            end
            in_valid = 1'b0;
            e = exp_q.pop_front();
            checks++; if (lat != e.lat) begin errors++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (out_c !== e.c) begin errors++; $display("FAIL mul_c[%0d]: got %h want %h", i, out_c, e.c); end
            checks++; if (out_st !== e.st) begin errors++; $display("FAIL mul_status[%0d]: got %b want %b", i, out_st, e.st); end
            repeat (3) begin
                @(negedge clk);
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_spurious[%0d]: got %b want 0", i, out_valid); end
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   lat, busy, seen;
        issue(4'd14, 16'h0123, 16'h0456);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_valid); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", out_ready); end
        checks++; if (out_c !== 16'h0000) begin errors++; $display("FAIL abort_c: got %h want 0000", out_c); end
        checks++; if (out_st !== 5'b00000) begin errors++; $display("FAIL abort_status: got %b want 00000", out_st); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen); end
        issue(4'd0, 16'd2, 16'd3);
        wait_valid(lat, busy);
        e = exp_q.pop_front();
        checks++; if (lat != 1) begin errors++; $display("FAIL post_reset_lat: got %0d want 1", lat); end
        checks++; if (out_c !== e.c) begin errors++; $display("FAIL post_reset_c: got %h want %h", out_c, e.c); end
        checks++; if (out_st !== e.st) begin errors++; $display("FAIL post_reset_status: got %b want %b", out_st, e.st); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_shift();
        test_mul();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
